// File: rtl/or7_equiv_seq.sv
// Exhaustive equivalence sweeper: drives all 128 values of a 7-bit stimulus to
// two circuits, waits SETTLE cycles per vector and records mismatch statistics.
module or7_equiv_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [6:0] vec,
  input  logic [1:0] oa,
  input  logic [1:0] ob,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mm_valid,
  output logic [6:0] mm_vec,
  output logic [1:0] mm_oa,
  output logic [1:0] mm_ob,
  output logic [7:0] mm_count
);

  typedef enum logic [1:0] {IDLE, WAIT, COMPARE, DONE} state_t;

  localparam int unsigned LAST_WAIT_INT = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]  LAST_WAIT     = LAST_WAIT_INT[3:0];
  localparam state_t      AFTER_VEC     = (SETTLE == 0) ? COMPARE : WAIT;

  state_t     state, state_next;
  logic [6:0] vec_next;
  logic [3:0] cnt, cnt_next;
  logic       done_next, pass_next, mm_valid_next;
  logic [6:0] mm_vec_next;
  logic [1:0] mm_oa_next, mm_ob_next;
  logic [7:0] mm_count_next;

  assign busy = (state == WAIT) || (state == COMPARE);

  always_comb begin
    state_next    = state;
    vec_next      = vec;
    cnt_next      = cnt;
    done_next     = 1'b0;
    pass_next     = pass;
    mm_valid_next = mm_valid;
    mm_vec_next   = mm_vec;
    mm_oa_next    = mm_oa;
    mm_ob_next    = mm_ob;
    mm_count_next = mm_count;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          vec_next      = 7'd0;
          cnt_next      = 4'd0;
          pass_next     = 1'b0;
          mm_valid_next = 1'b0;
          mm_vec_next   = 7'd0;
          mm_oa_next    = 2'd0;
          mm_ob_next    = 2'd0;
          mm_count_next = 8'd0;
          state_next    = AFTER_VEC;
        end
      end
      WAIT: begin
        if (abort) begin
          vec_next   = 7'd0;
          state_next = IDLE;
        end else if (cnt == LAST_WAIT) begin
          state_next = COMPARE;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      COMPARE: begin
        if (abort) begin
          // Aborted vector is not scored; results so far are kept.
          vec_next   = 7'd0;
          state_next = IDLE;
        end else begin
          if (oa != ob) begin
            if (mm_count != 8'd128) mm_count_next = mm_count + 8'd1;
            if (!mm_valid) begin
              mm_valid_next = 1'b1;
              mm_vec_next   = vec;
              mm_oa_next    = oa;
              mm_ob_next    = ob;
            end
          end
          if (vec == 7'd127) begin
            vec_next   = 7'd0;
            state_next = DONE;
          end else begin
            vec_next   = vec + 7'd1;
            cnt_next   = 4'd0;
            state_next = AFTER_VEC;
          end
        end
      end
      DONE: begin
        done_next  = 1'b1;
        pass_next  = (mm_count == 8'd0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= 7'd0;
      cnt      <= 4'd0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mm_valid <= 1'b0;
      mm_vec   <= 7'd0;
      mm_oa    <= 2'd0;
      mm_ob    <= 2'd0;
      mm_count <= 8'd0;
    end else begin
      state    <= state_next;
      vec      <= vec_next;
      cnt      <= cnt_next;
      done     <= done_next;
      pass     <= pass_next;
      mm_valid <= mm_valid_next;
      mm_vec   <= mm_vec_next;
      mm_oa    <= mm_oa_next;
      mm_ob    <= mm_ob_next;
      mm_count <= mm_count_next;
    end
  end

endmodule

// File: tb/tb_or7_equiv_seq.sv
// Bench for or7_equiv_seq: two instances (SETTLE=0 and SETTLE=2) sweep a
// small reference circuit with injected output faults in lockstep.
module tb_or7_equiv_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [6:0] vec_o    [2];
  logic [1:0] oa       [2];
  logic [1:0] ob       [2];
  logic       busy     [2];
  logic       done     [2];
  logic       pass     [2];
  logic       mm_valid [2];
  logic [6:0] mm_vec   [2];
  logic [1:0] mm_oa    [2];
  logic [1:0] mm_ob    [2];
  logic [7:0] mm_count [2];

  int checks = 0;
  int failures = 0;

  // Fault configuration shared by both circuits B.
  int         cur_fv1 = -1;
  int         cur_fv2 = -1;
  logic [1:0] cur_m1 = 2'b00;
  logic [1:0] cur_m2 = 2'b00;
  logic [1:0] cur_all = 2'b00;

  always #5 clk = ~clk;

  or7_equiv_seq #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec(vec_o[0]),
    .oa(oa[0]), .ob(ob[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .mm_valid(mm_valid[0]), .mm_vec(mm_vec[0]), .mm_oa(mm_oa[0]),
    .mm_ob(mm_ob[0]), .mm_count(mm_count[0])
  );

  or7_equiv_seq #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec(vec_o[1]),
    .oa(oa[1]), .ob(ob[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .mm_valid(mm_valid[1]), .mm_vec(mm_vec[1]), .mm_oa(mm_oa[1]),
    .mm_ob(mm_ob[1]), .mm_count(mm_count[1])
  );

  function automatic logic [1:0] model(input logic [6:0] v);
    return {|v[6:4], ^v[3:0]};
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      oa[d] = {|vec_o[d][6:4], ^vec_o[d][3:0]};
      ob[d] = oa[d] ^ cur_all
              ^ ((int'(vec_o[d]) == cur_fv1) ? cur_m1 : 2'b00)
              ^ ((int'(vec_o[d]) == cur_fv2) ? cur_m2 : 2'b00);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         fv1;
    logic [1:0] m1;
    int         fv2;
    logic [1:0] m2;
    logic [1:0] all_m;
    int         rep;
    int         e_pass;
    int         e_cnt;
    int         e_valid;
    int         e_vec;
    logic [1:0] e_x;
  } row_t;

  row_t rows [7];

  task automatic set_faults(input row_t r);
    cur_fv1 = r.fv1;
    cur_m1  = r.m1;
    cur_fv2 = r.fv2;
    cur_m2  = r.m2;
    cur_all = r.all_m;
  endtask

  // Called at a negedge; start is accepted on the following rising edge (cycle 0).
  task automatic run_row(input int idx, input row_t r);
    int  first_done [2];
    int  n_done [2];
    int  track_err;
    bit  pulsed;
    int  settle;
    int  last;
    logic [1:0] exp_oa;
    set_faults(r);
    first_done = '{-1, -1};
    n_done = '{0, 0};
    track_err = 0;
    pulsed = 0;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        settle = (d == 0) ? 0 : 2;
        last = 128 * (settle + 1);
        if (done[d]) begin
          if (first_done[d] < 0) first_done[d] = cyc;
          n_done[d]++;
        end
        if (int'(busy[d]) != ((cyc < last) ? 1 : 0)) track_err++;
        if (int'(vec_o[d]) != ((cyc < last) ? cyc / (settle + 1) : 0)) track_err++;
      end
      if (cyc == 1) begin
        check($sformatf("r%0d_start_clears_count", idx), int'(mm_count[1]), 0);
        check($sformatf("r%0d_start_clears_pass", idx), int'(pass[1]), 0);
      end
      if (r.rep >= 0 && !pulsed && int'(vec_o[1]) == r.rep) begin
        start = 1'b1;
        pulsed = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (r.rep >= 0) check($sformatf("r%0d_repulse_applied", idx), int'(pulsed), 1);
    check($sformatf("r%0d_vec_busy_track", idx), track_err, 0);
    exp_oa = r.e_valid ? model(7'(r.e_vec)) : 2'b00;
    for (int d = 0; d < 2; d++) begin
      settle = (d == 0) ? 0 : 2;
      check($sformatf("r%0d_d%0d_done_cycle", idx, d), first_done[d], 128 * (settle + 1) + 1);
      check($sformatf("r%0d_d%0d_done_pulses", idx, d), n_done[d], 1);
      check($sformatf("r%0d_d%0d_pass", idx, d), int'(pass[d]), r.e_pass);
      check($sformatf("r%0d_d%0d_mm_count", idx, d), int'(mm_count[d]), r.e_cnt);
      check($sformatf("r%0d_d%0d_mm_valid", idx, d), int'(mm_valid[d]), r.e_valid);
      check($sformatf("r%0d_d%0d_mm_vec", idx, d), int'(mm_vec[d]), r.e_vec);
      check($sformatf("r%0d_d%0d_mm_oa", idx, d), int'(mm_oa[d]), int'(exp_oa));
      check($sformatf("r%0d_d%0d_mm_ob", idx, d), int'(mm_ob[d]), int'(exp_oa ^ r.e_x));
    end
    $display("row %0d: done_cycles=%0d/%0d pass=%0d/%0d mm_count=%0d/%0d mm_vec=%0d",
             idx, first_done[0], first_done[1], pass[0], pass[1], mm_count[0], mm_count[1], mm_vec[1]);
  endtask

  task automatic wait_vec2(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (busy[1] && int'(vec_o[1]) == target) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_nonzero_outputs", tag, d),
            int'({vec_o[d], busy[d], done[d], pass[d], mm_valid[d], mm_vec[d],
                  mm_oa[d], mm_ob[d], mm_count[d]}), 0);
    end
  endtask

  initial begin
    bit ok;
    int nd;
    //            fv1  m1     fv2  m2     all    rep pass cnt val vec x
    rows[0] = '{  -1, 2'b00,  -1, 2'b00, 2'b00,  -1, 1,   0,  0,  0, 2'b00};
    rows[1] = '{   5, 2'b10,  -1, 2'b00, 2'b00,  -1, 0,   1,  1,  5, 2'b10};
    rows[2] = '{   3, 2'b01, 100, 2'b11, 2'b00,  -1, 0,   2,  1,  3, 2'b01};
    rows[3] = '{ 127, 2'b01,  -1, 2'b00, 2'b00,  -1, 0,   1,  1, 127, 2'b01};
    rows[4] = '{   0, 2'b11,  -1, 2'b00, 2'b00,  -1, 0,   1,  1,  0, 2'b11};
    rows[5] = '{  -1, 2'b00,  -1, 2'b00, 2'b01,  -1, 0, 128,  1,  0, 2'b01};
    rows[6] = '{  -1, 2'b00,  -1, 2'b00, 2'b00,  10, 1,   0,  0,  0, 2'b00};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // Abort mid-sweep at vec=40 of the SETTLE=2 instance.
    set_faults(rows[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec2(40, ok);
    check("abort_reach_vec40", int'(ok), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_d%0d_busy", d), int'(busy[d]), 0);
      check($sformatf("abort_d%0d_vec", d), int'(vec_o[d]), 0);
    end
    nd = 0;
    for (int i = 0; i < 400; i++) begin
      if (done[0] || done[1]) nd++;
      @(negedge clk);
    end
    check("abort_no_done", nd, 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_d%0d_pass", d), int'(pass[d]), 0);
      check($sformatf("abort_d%0d_mm_valid", d), int'(mm_valid[d]), 1);
      check($sformatf("abort_d%0d_mm_vec", d), int'(mm_vec[d]), 5);
      check($sformatf("abort_d%0d_mm_count", d), int'(mm_count[d]), 1);
    end
    $display("abort: busy=%0d/%0d vec=%0d/%0d mm_vec=%0d", busy[0], busy[1], vec_o[0], vec_o[1], mm_vec[1]);

    // start and abort together in IDLE must not launch a sweep.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("start_abort_busy0", int'(busy[0]), 0);
    check("start_abort_busy2", int'(busy[1]), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_still_idle", int'(busy[0] | busy[1]), 0);
    $display("start+abort: busy=%0d/%0d", busy[0], busy[1]);

    // Asynchronous reset mid-cycle at vec=64, then a fresh sweep.
    set_faults(rows[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec2(64, ok);
    check("reset_reach_vec64", int'(ok), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    $display("async reset: busy=%0d vec=%0d mm_valid=%0d", busy[1], vec_o[1], mm_valid[1]);
    @(negedge clk);
    rst_n = 1'b1;
    run_row(7, rows[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
